// File: rtl/tmds_decoder_align.sv
// tmds_decoder_align: finds the TMDS word boundary by control-token hunting and decodes aligned words to vd/cd/vde; also reports locked and the bit offset 0..9
module tmds_decoder_align #(
  parameter int LOCK_TOKENS  = 8,
  parameter int HUNT_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] tmds_word,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       locked,
  output logic [3:0] offset
);
  localparam int TW = $clog2(LOCK_TOKENS + 1);
  localparam int HW = $clog2(HUNT_TIMEOUT + 1);
  localparam int LW = $clog2(LOSS_TIMEOUT + 1);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t state, state_n;
  logic [9:0] r_prev, r_aligned;
  logic [19:0] window;
  logic [TW-1:0] tok_cnt, tok_cnt_n;
  logic [HW-1:0] hunt_cnt, hunt_cnt_n;
  logic [LW-1:0] loss_cnt, loss_cnt_n;
  logic [3:0] offset_n;
  logic settle, settle_n, is_tok;
  logic [1:0] tok_cd;
  logic [7:0] q, dec;
  assign window = {tmds_word, r_prev};
  assign is_tok = r_aligned inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  assign tok_cd = (r_aligned == 10'b0010101011) ? 2'b01 :
                  (r_aligned == 10'b0101010100) ? 2'b10 :
                  (r_aligned == 10'b1010101011) ? 2'b11 : 2'b00;
  assign q = r_aligned[9] ? ~r_aligned[7:0] : r_aligned[7:0];
  assign dec = {q[7:1] ^ q[6:0] ^ {7{~r_aligned[8]}}, q[0]};
  assign locked = state == LOCK;
  always_comb begin
    state_n = state;
    offset_n = offset;
    tok_cnt_n = tok_cnt;
    hunt_cnt_n = hunt_cnt;
    loss_cnt_n = loss_cnt;
    settle_n = 1'b0;
    if (state == HUNT) begin
      if (tok_cnt == TW'(LOCK_TOKENS)) begin
        state_n = LOCK;
        tok_cnt_n = '0;
        hunt_cnt_n = '0;
        loss_cnt_n = '0;
      end else if (hunt_cnt == HW'(HUNT_TIMEOUT - 1)) begin
        offset_n = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
        tok_cnt_n = '0;
        hunt_cnt_n = '0;
        settle_n = 1'b1;
      end else begin
        hunt_cnt_n = hunt_cnt + 1'b1;
        // r_aligned was sliced at the old offset right after a slip, so skip it
        tok_cnt_n = (settle || !is_tok) ? '0 : tok_cnt + 1'b1;
      end
    end else begin
      loss_cnt_n = is_tok ? '0 : loss_cnt + 1'b1;
      if (!is_tok && loss_cnt == LW'(LOSS_TIMEOUT - 1)) begin
        state_n = HUNT;
        loss_cnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state <= HUNT;
      offset <= '0;
      r_prev <= '0;
      r_aligned <= '0;
      tok_cnt <= '0;
      hunt_cnt <= '0;
      loss_cnt <= '0;
      settle <= 1'b0;
      vd <= '0;
      cd <= '0;
      vde <= 1'b0;
    end else begin
      state <= state_n;
      offset <= offset_n;
      r_prev <= tmds_word;
      r_aligned <= 10'(window >> offset);
      tok_cnt <= tok_cnt_n;
      hunt_cnt <= hunt_cnt_n;
      loss_cnt <= loss_cnt_n;
      settle <= settle_n;
      vde <= locked && !is_tok;
      vd <= (locked && !is_tok) ? dec : '0;
      cd <= !locked ? 2'b00 : is_tok ? tok_cd : cd;
    end
  end
endmodule
